// File: rtl/seq_multiply_n_if.sv
// Nios II multicycle custom-instruction bus for the seq_multiply_n block.
// The master drives operands and handshake; the slave (multiplier) returns done/result.
interface seq_multiply_n_if #(
  parameter int WIDTH = 32
);
  logic             clk_en;
  logic             start;
  logic [1:0]       n;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output clk_en, start, n, dataa, datab,
    input  done, result
  );

  modport slave (
    input  clk_en, start, n, dataa, datab,
    output done, result
  );
endinterface

// File: rtl/seq_multiply_n.sv
// Parametrised multicycle shift-add multiplier for a Nios II custom-instruction slot.
// n[1] selects signed mode (operate on magnitudes, negate at the end),
// n[0] selects the high word of the 2*WIDTH product.
// With EARLY_EXIT set, RUN stops once the remaining multiplier bits are all zero.
module seq_multiply_n #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  seq_multiply_n_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic [1:0]           n_q, n_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     a_sel_s, b_sel_s;

  // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1) as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    if (x[WIDTH-1]) begin
      return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return x;
    end
  endfunction

  // Next-state and datapath computation for all registers.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    n_d      = n_q;
    done_d   = 1'b0;
    if (bus.n[1]) begin
      a_sel_s = mag(bus.dataa);
      b_sel_s = mag(bus.datab);
    end else begin
      a_sel_s = bus.dataa;
      b_sel_s = bus.datab;
    end

    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse is not taken.
        if (bus.start && !done_q) begin
          n_d      = bus.n;
          sign_d   = bus.n[1] & (bus.dataa[WIDTH-1] ^ bus.datab[WIDTH-1]);
          mcand_d  = {{WIDTH{1'b0}}, a_sel_s};
          mplier_d = b_sel_s;
          acc_d    = {(2*WIDTH){1'b0}};
          cnt_d    = CW'(WIDTH);
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        // Add and shift in the same cycle.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        if ((cnt_d == {CW{1'b0}}) || (EARLY_EXIT && (mplier_d == {WIDTH{1'b0}}))) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        if (sign_q) begin
          acc_d = ~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
          acc_d = acc_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (n_q[0]) begin
          result_d = acc_q[2*WIDTH-1:WIDTH];
        end else begin
          result_d = acc_q[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; clk_en low freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      sign_q   <= 1'b0;
      n_q      <= 2'b00;
      done_q   <= 1'b0;
    end else if (bus.clk_en) begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      n_q      <= n_d;
      done_q   <= done_d;
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_seq_multiply_n.sv
// Scoreboard bench for seq_multiply_n: one instance without and one with early exit,
// both driven with identical stimulus; a negedge monitor pops expectations on done.
module tb_seq_multiply_n;

  localparam int W = 32;

  typedef struct {
    logic [31:0] res;
    longint      edge_n;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset;
  longint raw_cyc = 0;
  longint en_cyc  = 0;
  longint start_raw = 0;
  longint done_raw0 = 0;
  int     checks = 0;
  int     errors = 0;
  exp_t   q0[$];
  exp_t   q1[$];
  logic [31:0] last_res[2];

  always #5 clk = ~clk;

  seq_multiply_n_if #(.WIDTH(W)) bus0 ();
  seq_multiply_n_if #(.WIDTH(W)) bus1 ();

  seq_multiply_n #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  seq_multiply_n #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  // Raw and enabled clock-edge counters.
  always @(posedge clk) begin
    raw_cyc <= raw_cyc + 1;
    if (bus0.clk_en) en_cyc <= en_cyc + 1;
  end

  // Reference product: exact 2W-bit product by wide arithmetic, then word select.
  function automatic logic [31:0] model_res(input logic [1:0] nn, input logic [31:0] a, input logic [31:0] b);
    logic [127:0] ea, eb, p;
    if (nn[1]) begin
      ea = {{96{a[31]}}, a};
      eb = {{96{b[31]}}, b};
    end else begin
      ea = {96'd0, a};
      eb = {96'd0, b};
    end
    p = ea * eb;
    return nn[0] ? p[63:32] : p[31:0];
  endfunction

  // Number of RUN cycles: WIDTH, or the bit length of |datab| (at least 1) with early exit.
  function automatic int model_runs(input bit early, input logic [1:0] nn, input logic [31:0] b);
    logic [32:0] m;
    int r;
    if (!early) return W;
    if (nn[1] && b[31]) m = 33'd0 - {b[31], b};
    else m = {1'b0, b};
    r = 0;
    for (int i = 0; i < 33; i++) if (m[i]) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  task automatic set_en(input logic v);
    bus0.clk_en = v;
    bus1.clk_en = v;
  endtask

  task automatic drive(input logic s, input logic [1:0] nn, input logic [31:0] a, input logic [31:0] b);
    bus0.start = s; bus1.start = s;
    bus0.n = nn;    bus1.n = nn;
    bus0.dataa = a; bus1.dataa = a;
    bus0.datab = b; bus1.datab = b;
  endtask

  task automatic issue(input logic [1:0] nn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    set_en(1'b1);
    drive(1'b1, nn, a, b);
    e.res    = model_res(nn, a, b);
    e.edge_n = en_cyc + 3 + model_runs(1'b0, nn, b);
    q0.push_back(e);
    e.edge_n = en_cyc + 3 + model_runs(1'b1, nn, b);
    q1.push_back(e);
    start_raw = raw_cyc + 1;
    @(negedge clk);
    drive(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout pending0=%0d pending1=%0d required=0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic mon(input int k, input logic d, input logic [31:0] r);
    exp_t e;
    int   sz;
    sz = (k == 0) ? q0.size() : q1.size();
    if (d) begin
      checks++;
      if (sz == 0) begin
        errors++;
        $display("FAIL unexpected_done dut%0d result=%h", k, r);
      end else begin
        if (k == 0) e = q0.pop_front();
        else e = q1.pop_front();
        if (r !== e.res) begin
          errors++;
          $display("FAIL result dut%0d got=%h exp=%h", k, r, e.res);
        end
        checks++;
        if (en_cyc != e.edge_n) begin
          errors++;
          $display("FAIL latency dut%0d got_edge=%0d exp_edge=%0d", k, en_cyc, e.edge_n);
        end
      end
      last_res[k] = r;
      if (k == 0) done_raw0 = raw_cyc;
    end else begin
      checks++;
      if (r !== last_res[k]) begin
        errors++;
        $display("FAIL result_hold dut%0d got=%h exp=%h", k, r, last_res[k]);
      end
    end
  endtask

  // Monitor: compare on done, check result holds otherwise.
  always @(negedge clk) begin
    if (reset) begin
      mon(0, bus0.done, bus0.result);
      mon(1, bus1.done, bus1.result);
    end else begin
      last_res[0] = 32'd0;
      last_res[1] = 32'd0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp_v);
    end
  endtask

  logic [1:0]  dn[10];
  logic [31:0] da[10];
  logic [31:0] db[10];

  initial begin
    dn = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b11};
    da = '{32'h0000_1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
           32'h8000_0000, 32'h8000_0000, 32'h0000_0055, 32'h0000_0009, 32'h7FFF_FFFF};
    db = '{32'h0000_0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0007,
           32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0005, 32'h8000_0000};
    last_res[0] = 32'd0;
    last_res[1] = 32'd0;
    reset = 1'b0;
    set_en(1'b1);
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("reset_done0", {31'd0, bus0.done}, 32'd0);
    chk("reset_result0", bus0.result, 32'd0);
    chk("reset_done1", {31'd0, bus1.done}, 32'd0);
    chk("reset_result1", bus1.result, 32'd0);
    reset = 1'b1;

    // Directed cases from the reference list.
    for (int i = 0; i < 10; i++) begin
      issue(dn[i], da[i], db[i]);
      wait_idle();
    end

    // clk_en stall of 10 cycles around RUN cycle 7.
    issue(2'b00, 32'h0000_1234, 32'hF000_0010);
    repeat (6) @(negedge clk);
    set_en(1'b0);
    repeat (10) @(negedge clk);
    set_en(1'b1);
    wait_idle();
    chk("stall_latency", 32'(done_raw0 - start_raw), 32'(W + 2 + 10));

    // Second start mid-RUN must be ignored.
    issue(2'b10, 32'hFFFF_0003, 32'h8000_0010);
    repeat (5) @(negedge clk);
    drive(1'b1, 2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    wait_idle();

    // Randomized operations, biased toward small multipliers and corner values.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 255));
        1: b = (($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF);
        2: a = 32'($urandom_range(0, 15));
        default: ;
      endcase
      issue(2'($urandom_range(0, 3)), a, b);
      wait_idle();
    end

    // Reset pulsed mid-RUN abandons the operation.
    issue(2'b00, 32'h0000_0005, 32'h8000_0003);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_done0", {31'd0, bus0.done}, 32'd0);
    chk("midrst_result0", bus0.result, 32'd0);
    chk("midrst_done1", {31'd0, bus1.done}, 32'd0);
    chk("midrst_result1", bus1.result, 32'd0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    issue(2'b00, 32'd6, 32'd7);
    wait_idle();
    chk("after_reset_42", bus0.result, 32'd42);
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
